// File: rtl/arb_2ne1.sv
// arb_2ne1 -- two-requester arbiter for the shared port behind mux2ne1.
// Requester 0 is instruction fetch and requester 1 is data access.
// Ties are settled by alternation: the requester not granted last wins.
// A grant is released on done, when the owner drops its request, or when
// the owner has held the port for TIMEOUT cycles. On release the next
// owner is chosen on the same edge, so a handoff has no idle gap.
// The releasing owner's request still takes part in that decision.
// A release caused only by the hold limit raises timeout for one cycle.
// All outputs come straight from flops.

module arb_2ne1 #(
    parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic done,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Hold count at which the current owner is forced off the port.
    localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     pick;
    state_t     next_state;
    logic       last;        // 1 = requester 1 was granted most recently
    logic [7:0] hold_cnt;
    logic       owner_req;
    logic       expire;
    logic       release_now;
    logic       forced;
    logic       decide;
    logic       new_grant;

    // Arbitration decision and release conditions for the current cycle.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        owner_req   = 1'b0;
        expire      = 1'b0;
        release_now = 1'b0;
        forced      = 1'b0;
        pick        = IDLE;

        case (state)
            OWN0:    owner_req = req0;
            OWN1:    owner_req = req1;
            default: owner_req = 1'b0;
        endcase

        expire = (hold_cnt == HOLD_MAX);

        if (state != IDLE) begin
            release_now = done || !owner_req || expire;
            // Only the hold limit caused this release: no done and the
            // owner still wants the port.
            forced = expire && !done && owner_req;
        end

        // The releasing owner's request still counts here.
        if (req0 && req1) begin
            pick = last ? OWN0 : OWN1;
        end else if (req0) begin
            pick = OWN0;
        end else if (req1) begin
            pick = OWN1;
        end else begin
            pick = IDLE;
        end

        // A new decision is taken from IDLE or on any release.
        decide     = (state == IDLE) || release_now;
        next_state = decide ? pick : state;
        // A re-grant to the same requester is also a new grant.
        new_grant  = decide && (pick != IDLE);
    end

    // State, hold counter, last-granted record and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so that
        // every flop samples values from before this edge.
        if (reset) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            s        <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
            // Requester 0 wins the first tie after reset.
            last     <= 1'b1;
        end else begin
            state   <= next_state;
            gnt0    <= (next_state == OWN0);
            gnt1    <= (next_state == OWN1);
            busy    <= (next_state != IDLE);
            timeout <= forced;

            // The select holds its last value while idle.
            if (next_state == OWN0) begin
                s <= 1'b0;
            end else if (next_state == OWN1) begin
                s <= 1'b1;
            end

            if (new_grant) begin
                hold_cnt <= 8'd0;
                last     <= (pick == OWN1);
            end else if (next_state == IDLE) begin
                hold_cnt <= 8'd0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_arb_2ne1.sv
// Testbench for arb_2ne1 with TIMEOUT=4.
// Each vector gives the inputs for one rising edge and the outputs
// expected after that edge, as {gnt0, gnt1, s, busy, timeout}.
// The stimulus process queues the expectation. The monitor process
// compares it one step after the edge and also checks the grant
// invariants on every cycle.

module tb_arb_2ne1;

    logic clock;
    logic reset;
    logic req0;
    logic req1;
    logic done;
    logic gnt0;
    logic gnt1;
    logic s;
    logic busy;
    logic timeout;

    typedef struct {
        int         idx;
        logic [4:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_n    = 0;

    arb_2ne1 #(.TIMEOUT(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .done    (done),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .s       (s),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one vector ahead of the next rising edge and queue its
    // expected outputs.
    task automatic drive(input logic r, input logic q0, input logic q1,
                         input logic d, input logic [4:0] e);
        exp_t t;
        @(negedge clock);
        reset = r;
        req0  = q0;
        req1  = q1;
        done  = d;
        t.idx = vec_n;
        t.exp = e;
        exp_q.push_back(t);
        vec_n++;
    endtask

    // Monitor: invariants every cycle, and the scoreboard entry when one
    // is pending.
    always @(posedge clock) begin
        exp_t       t;
        logic [4:0] obs;
        #1;
        obs = {gnt0, gnt1, s, busy, timeout};

        checks++;
        if (gnt0 && gnt1) begin
            failures++;
            $display("FAIL mutex t=%0t: gnt0=%b gnt1=%b, required not both high",
                     $time, gnt0, gnt1);
        end

        checks++;
        if (busy !== (gnt0 | gnt1)) begin
            failures++;
            $display("FAIL busy_or t=%0t: busy=%b, required %b",
                     $time, busy, gnt0 | gnt1);
        end

        checks++;
        if ((gnt0 && s !== 1'b0) || (gnt1 && s !== 1'b1)) begin
            failures++;
            $display("FAIL s_track t=%0t: s=%b with gnt0=%b gnt1=%b",
                     $time, s, gnt0, gnt1);
        end

        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            checks++;
            if (obs !== t.exp) begin
                failures++;
                $display("FAIL vec%0d {gnt0,gnt1,s,busy,timeout}: got %b required %b",
                         t.idx, obs, t.exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        done  = 1'b0;

        // Reset state, then done in IDLE has no effect.
        drive(1, 0, 0, 0, 5'b00000);
        drive(0, 0, 0, 1, 5'b00000);
        drive(0, 0, 0, 1, 5'b00000);

        // Both requesting, done every third cycle: grants alternate with no gap.
        drive(0, 1, 1, 0, 5'b10010);   // first tie goes to requester 0
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 1, 5'b01110);   // handoff to requester 1
        drive(0, 1, 1, 0, 5'b01110);
        drive(0, 1, 1, 0, 5'b01110);
        drive(0, 1, 1, 1, 5'b10010);   // back to requester 0
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 1, 5'b01110);

        // Reset during OWN1 with both requesting: IDLE with s=0, then OWN0.
        drive(1, 1, 1, 0, 5'b00000);
        drive(0, 1, 1, 0, 5'b10010);

        // Hold limit: OWN0 for exactly 4 cycles, then timeout with OWN1.
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 0, 5'b10010);
        drive(0, 1, 1, 0, 5'b01111);   // forced release, same-edge handoff
        drive(0, 1, 1, 0, 5'b01110);
        drive(0, 1, 1, 0, 5'b01110);
        drive(0, 1, 1, 0, 5'b01110);
        drive(0, 1, 1, 1, 5'b10010);   // done and expiry together: no timeout

        // Requests drop: back to IDLE.
        drive(0, 0, 0, 0, 5'b00000);

        // Requester 1 alone, then it drops: IDLE keeps s=1.
        drive(0, 0, 1, 0, 5'b01110);
        drive(0, 0, 1, 0, 5'b01110);
        drive(0, 0, 1, 0, 5'b01110);
        drive(0, 0, 1, 0, 5'b01110);
        drive(0, 0, 0, 0, 5'b00100);   // request drop at expiry is not a timeout
        drive(0, 0, 0, 1, 5'b00100);   // done ignored in IDLE

        // Re-grant to the same requester clears the hold counter.
        drive(0, 1, 0, 0, 5'b10010);
        drive(0, 1, 0, 1, 5'b10010);   // re-grant, counter back to 0
        drive(0, 1, 0, 0, 5'b10010);
        drive(0, 1, 0, 0, 5'b10010);
        drive(0, 1, 0, 0, 5'b10010);
        drive(0, 1, 0, 0, 5'b10011);   // forced release, re-granted to 0
        drive(0, 0, 0, 0, 5'b00000);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clock);
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_2ne1.md
ARB_2NE1 -- requirements
Module: arb_2ne1

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum number of cycles a grant is held without Done before forced release (legal range 1..255).
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req0  input  1  requester 0 (instruction fetch) requests the shared port.
REQ-005 Req1  input  1  requester 1 (data access) requests the shared port.
REQ-006 Done  input  1  current owner has finished its transfer; sampled only while a grant is active.
REQ-007 Gnt0  output  1  port granted to requester 0.
REQ-008 Gnt1  output  1  port granted to requester 1.
REQ-009 S  output  1  select for the downstream mux2ne1; 0 selects A0 (requester 0), 1 selects A1 (requester 1).
REQ-010 Busy  output  1  a grant is active.
REQ-011 Timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-012 The block SHALL implement states IDLE, OWN0, OWN1; all outputs SHALL be registered.
REQ-013 Gnt0 SHALL be high only in OWN0, Gnt1 only in OWN1; Gnt0 and Gnt1 SHALL never be high together.
REQ-014 Busy SHALL equal Gnt0 OR Gnt1.
REQ-015 S SHALL be 0 in OWN0, 1 in OWN1, and SHALL hold its last value in IDLE.
REQ-016 A 1-bit Last register SHALL record the most recently granted requester.
REQ-017 Arbitration decision (IDLE or on release): only Req0 -> OWN0; only Req1 -> OWN1; both -> the requester not equal to Last; neither -> IDLE.
REQ-018 Grant latency SHALL be one cycle: a request sampled in IDLE yields the grant in the following cycle.
REQ-019 Release SHALL occur when, in OWNn, Done=1, or Reqn=0, or the hold counter equals TIMEOUT-1.
REQ-020 On release the next state SHALL be chosen by REQ-017 in the same edge (no idle gap on handoff), with the releasing requester's Req still counted.
REQ-021 An 8-bit hold counter SHALL clear on every new grant (including re-grant to the same requester) and increment each cycle in OWNn without release.
REQ-022 Timeout SHALL pulse high for exactly the cycle following a release caused solely by the counter (Done=0, Reqn=1).
REQ-023 Done SHALL be ignored in IDLE.
REQ-024 Done and counter expiry in the same cycle SHALL count as normal release; Timeout SHALL stay 0.
REQ-025 Last SHALL update only on entry to OWN0/OWN1.

Reset
REQ-026 With Reset=1 at a rising edge, the block SHALL enter IDLE with Gnt0=0, Gnt1=0, Busy=0, S=0, Timeout=0, counter=0, Last=1 (so requester 0 wins the first tie).
REQ-027 Reset SHALL override any in-progress grant in the same edge; requests held through reset SHALL be arbitrated starting the cycle after Reset deasserts.

Verification
REQ-028 Reset, then Req0=Req1=1 held, Done pulsed every 3rd cycle -> grants alternate OWN0, OWN1, OWN0, ... with S tracking 0,1,0 and no IDLE cycle between.
REQ-029 Req1=1 alone at cycle 0 -> Gnt1=1, S=1, Busy=1 at cycle 1; Req1 drops at cycle 4 -> IDLE at cycle 5 with S still 1.
REQ-030 TIMEOUT=4, Req0 held, Done=0, Req1=1 -> OWN0 for exactly 4 cycles, Timeout=1 for one cycle, OWN1 entered on the same edge.
REQ-031 OWN1 active, Reset=1 for one cycle while Req0=Req1=1 -> IDLE with S=0, then OWN0 the following cycle.
REQ-032 Done=1 in IDLE with no requests -> no state change, all outputs 0; Done and expiry coincident -> release with Timeout=0.
REQ-033 Every cycle of every test: assert NOT(Gnt0 AND Gnt1), Busy=Gnt0|Gnt1, and S consistent with the active grant.
